// File: rtl/uart_frame_rx.sv
// uart_frame_rx: locks onto the AA BB CC sync header and rebuilds
// little-endian 24-bit samples from a UART byte stream.
// Ports: clk, reset_n (async, active low)
//   uart_rx_data[7:0], uart_rx_data_we : incoming byte + strobe
//   sample_data[23:0], sample_we, sample_index[10:0] : sample out
//   frame_start, frame_done, frame_abort : one-cycle event pulses
//   err_cnt[15:0] (saturating), frame_cnt[15:0] (wrapping)
module uart_frame_rx #(
  parameter int SAMPLES_PER_FRAME = 2048,
  parameter int TIMEOUT_CYCLES    = 1_000_000,
  parameter bit is_simulation     = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_data_we,
  output logic [23:0] sample_data,
  output logic        sample_we,
  output logic [10:0] sample_index,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [15:0] err_cnt,
  output logic [15:0] frame_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ?
    $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [10:0] S_LAST = 11'(SAMPLES_PER_FRAME - 1);

  typedef enum logic [2:0] {
    HUNT0, HUNT1, HUNT2, BYTE0, BYTE1, BYTE2
  } state_t;

  if (is_simulation) begin : g_sim
  end

  state_t        state, state_n;
  logic [7:0]    b0, b0_n, b1, b1_n;
  logic [10:0]   scnt, scnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [23:0]   data_n;
  logic [10:0]   idx_n;
  logic          we_n, start_n, done_n, abort_n, err_hit;
  logic [15:0]   err_n, fcnt_n;
  logic          is_aa, is_bb, is_cc;

  assign is_aa = (uart_rx_data == 8'hAA);
  assign is_bb = (uart_rx_data == 8'hBB);
  assign is_cc = (uart_rx_data == 8'hCC);

  always_comb begin
    state_n = state;
    b0_n    = b0;
    b1_n    = b1;
    scnt_n  = scnt;
    tcnt_n  = tcnt;
    data_n  = sample_data;
    idx_n   = sample_index;
    we_n    = 1'b0;
    start_n = 1'b0;
    done_n  = 1'b0;
    abort_n = 1'b0;
    err_hit = 1'b0;
    fcnt_n  = frame_cnt;
    if (uart_rx_data_we) begin
      // a byte always beats the timeout threshold
      tcnt_n = '0;
      unique case (state)
        HUNT0: if (is_aa) state_n = HUNT1;
        HUNT1: begin
          unique case (1'b1)
            is_bb: state_n = HUNT2;
            is_aa: err_hit = 1'b1;
            default: begin
              state_n = HUNT0;
              err_hit = 1'b1;
            end
          endcase
        end
        HUNT2: begin
          err_hit = 1'b1;
          unique case (1'b1)
            is_cc: begin
              state_n = BYTE0;
              scnt_n  = '0;
              start_n = 1'b1;
              err_hit = 1'b0;
            end
            is_aa: state_n = HUNT1;
            default: state_n = HUNT0;
          endcase
        end
        BYTE0: begin
          b0_n    = uart_rx_data;
          state_n = BYTE1;
        end
        BYTE1: begin
          b1_n    = uart_rx_data;
          state_n = BYTE2;
        end
        BYTE2: begin
          data_n  = {uart_rx_data, b1, b0};
          we_n    = 1'b1;
          idx_n   = scnt;
          scnt_n  = scnt + 11'd1;
          state_n = BYTE0;
          if (scnt == S_LAST) begin
            done_n  = 1'b1;
            fcnt_n  = frame_cnt + 16'd1;
            state_n = HUNT0;
          end
        end
        default: state_n = HUNT0;
      endcase
    end else if (state == HUNT0) begin
      tcnt_n = '0;
    end else if (tcnt == T_LAST) begin
      state_n = HUNT0;
      tcnt_n  = '0;
      abort_n = 1'b1;
      err_hit = 1'b1;
    end else begin
      tcnt_n = tcnt + TW'(1);
    end
    err_n = (err_hit && err_cnt != 16'hFFFF) ?
      err_cnt + 16'd1 : err_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HUNT0;
      b0           <= '0;
      b1           <= '0;
      scnt         <= '0;
      tcnt         <= '0;
      sample_data  <= '0;
      sample_we    <= 1'b0;
      sample_index <= '0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
      err_cnt      <= '0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_n;
      b0           <= b0_n;
      b1           <= b1_n;
      scnt         <= scnt_n;
      tcnt         <= tcnt_n;
      sample_data  <= data_n;
      sample_we    <= we_n;
      sample_index <= idx_n;
      frame_start  <= start_n;
      frame_done   <= done_n;
      frame_abort  <= abort_n;
      err_cnt      <= err_n;
      frame_cnt    <= fcnt_n;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed scenario tasks for uart_frame_rx
// with hand-computed expectations.
module tb_uart_frame_rx;

  localparam int SPF = 2048;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_data_we = 1'b0;
  logic [23:0] sample_data;
  logic        sample_we;
  logic [10:0] sample_index;
  logic        frame_start, frame_done, frame_abort;
  logic [15:0] err_cnt, frame_cnt;

  int total = 0;
  int bad = 0;

  int ns, nstart, ndone, nabort, done_idx, overlap;
  logic [23:0] cap_data [SPF];
  logic [10:0] cap_idx  [SPF];

  uart_frame_rx #(
    .SAMPLES_PER_FRAME(SPF),
    .TIMEOUT_CYCLES(TO),
    .is_simulation(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .uart_rx_data(uart_rx_data),
    .uart_rx_data_we(uart_rx_data_we),
    .sample_data(sample_data),
    .sample_we(sample_we),
    .sample_index(sample_index),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .frame_abort(frame_abort),
    .err_cnt(err_cnt),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample_we) begin
      if (ns < SPF) begin
        cap_data[ns] = sample_data;
        cap_idx[ns]  = sample_index;
      end
      ns++;
    end
    if (frame_start) nstart++;
    if (frame_done) begin
      ndone++;
      done_idx = sample_we ? int'(sample_index) : -1;
    end
    if (frame_abort) begin
      nabort++;
      if (sample_we) overlap++;
    end
    if (frame_start && (sample_we || frame_done || frame_abort))
      overlap++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    uart_rx_data    = b;
    uart_rx_data_we = 1'b1;
    @(posedge clk);
    #1;
    uart_rx_data_we = 1'b0;
  endtask

  task automatic clr_mon();
    ns = 0; nstart = 0; ndone = 0; nabort = 0;
    done_idx = -2; overlap = 0;
    for (int i = 0; i < SPF; i++) begin
      cap_data[i] = 'x;
      cap_idx[i]  = 'x;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    clr_mon();
  endtask

  function automatic logic [23:0] expv(input int i, input bit k);
    return k ? 24'hCCBBAA : 24'h010203 + 24'(i);
  endfunction

  task automatic send_header();
    send(8'hAA); send(8'hBB); send(8'hCC);
  endtask

  task automatic send_body(input int n, input bit k);
    logic [23:0] v;
    for (int i = 0; i < n; i++) begin
      v = expv(i, k);
      send(v[7:0]); send(v[15:8]); send(v[23:16]);
    end
  endtask

  function automatic int count_bad(input bit k);
    int n = 0;
    for (int i = 0; i < SPF; i++)
      if (cap_data[i] !== expv(i, k) || cap_idx[i] !== 11'(i))
        n++;
    return n;
  endfunction

  task automatic test_reset();
    #2 reset_n = 1'b0;
    tick(2);
    total++;
    if (sample_data !== 24'h0) begin
      bad++; $display("FAIL rst_data: got %h want 0", sample_data);
    end
    total++;
    if ({sample_we, frame_start, frame_done, frame_abort} !== 4'b0) begin
      bad++; $display("FAIL rst_pulses: got %b%b%b%b want 0000",
        sample_we, frame_start, frame_done, frame_abort);
    end
    total++;
    if ({sample_index, err_cnt, frame_cnt} !== 43'h0) begin
      bad++; $display("FAIL rst_cnts: idx=%0d err=%0d fc=%0d want 0",
        sample_index, err_cnt, frame_cnt);
    end
    reset_n = 1'b1;
    tick(1);
    clr_mon();
    send(8'hCC);
    tick(2);
    total++;
    if (nstart !== 0 || err_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_hunt0: starts=%0d err=%0d want 0 0",
        nstart, err_cnt);
    end
  endtask

  task automatic test_clean_frame();
    do_reset();
    send_header();
    total++;
    if (frame_start !== 1'b1) begin
      bad++; $display("FAIL clean_start: got %b want 1", frame_start);
    end
    send_body(SPF, 1'b0);
    total++;
    if ({frame_done, sample_we} !== 2'b11 ||
        sample_data !== expv(SPF-1, 1'b0)) begin
      bad++; $display("FAIL clean_last: done=%b we=%b data=%h want 1 1 %h",
        frame_done, sample_we, sample_data, expv(SPF-1, 1'b0));
    end
    tick(2);
    total++;
    if (ns !== SPF || count_bad(1'b0) !== 0) begin
      bad++; $display("FAIL clean_samples: n=%0d badsamp=%0d want %0d 0",
        ns, count_bad(1'b0), SPF);
    end
    total++;
    if (nstart !== 1 || ndone !== 1 || done_idx !== SPF-1) begin
      bad++; $display("FAIL clean_events: st=%0d dn=%0d di=%0d want 1 1 %0d",
        nstart, ndone, done_idx, SPF-1);
    end
    total++;
    if (frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      bad++; $display("FAIL clean_cnts: fc=%0d err=%0d want 1 0",
        frame_cnt, err_cnt);
    end
    total++;
    if (sample_we !== 1'b0 || sample_data !== expv(SPF-1, 1'b0) ||
        nabort !== 0 || overlap !== 0) begin
      bad++; $display("FAIL clean_hold: we=%b data=%h ab=%0d ov=%0d",
        sample_we, sample_data, nabort, overlap);
    end
  endtask

  task automatic test_sync_recovery();
    logic [7:0] seq [8];
    seq = '{8'h55, 8'hAA, 8'hAA, 8'hBB, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    do_reset();
    for (int i = 0; i < 3; i++) send(seq[i]);
    total++;
    if (err_cnt !== 16'd1) begin
      bad++; $display("FAIL sync_aa_aa: err=%0d want 1", err_cnt);
    end
    for (int i = 3; i < 8; i++) send(seq[i]);
    send_body(SPF, 1'b0);
    tick(2);
    total++;
    if (err_cnt !== 16'd2) begin
      bad++; $display("FAIL sync_err: got %0d want 2", err_cnt);
    end
    total++;
    if (ns !== SPF || count_bad(1'b0) !== 0 || nstart !== 1 ||
        frame_cnt !== 16'd1) begin
      bad++; $display("FAIL sync_frame: n=%0d bs=%0d st=%0d fc=%0d",
        ns, count_bad(1'b0), nstart, frame_cnt);
    end
  endtask

  task automatic test_header_errors();
    do_reset();
    send(8'hAA); send(8'hBB); send(8'hAA); send(8'hBB); send(8'hCC);
    total++;
    if (frame_start !== 1'b1 || err_cnt !== 16'd1) begin
      bad++; $display("FAIL hunt2_aa: start=%b err=%0d want 1 1",
        frame_start, err_cnt);
    end
    do_reset();
    send(8'hAA); send(8'h11); send(8'hBB); send(8'hCC);
    tick(2);
    total++;
    if (nstart !== 0 || err_cnt !== 16'd1) begin
      bad++; $display("FAIL hunt1_other: starts=%0d err=%0d want 0 1",
        nstart, err_cnt);
    end
  endtask

  task automatic test_data_like_sync();
    do_reset();
    send_header();
    send_body(SPF, 1'b1);
    tick(2);
    total++;
    if (ns !== SPF || count_bad(1'b1) !== 0) begin
      bad++; $display("FAIL lsync_samples: n=%0d bs=%0d want %0d 0",
        ns, count_bad(1'b1), SPF);
    end
    total++;
    if (nstart !== 1 || frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      bad++; $display("FAIL lsync_events: st=%0d fc=%0d err=%0d want 1 1 0",
        nstart, frame_cnt, err_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_header();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    tick(TO - 1);
    total++;
    if (frame_abort !== 1'b0 || nabort !== 0) begin
      bad++; $display("FAIL to_early: abort=%b n=%0d want 0 0",
        frame_abort, nabort);
    end
    tick(1);
    total++;
    if (frame_abort !== 1'b1) begin
      bad++; $display("FAIL to_pulse: got %b want 1", frame_abort);
    end
    tick(1);
    total++;
    if (frame_abort !== 1'b0 || nabort !== 1) begin
      bad++; $display("FAIL to_width: abort=%b n=%0d want 0 1",
        frame_abort, nabort);
    end
    total++;
    if (ns !== 1 || cap_data[0] !== 24'h332211 || ndone !== 0) begin
      bad++; $display("FAIL to_samples: n=%0d d=%h dn=%0d want 1 332211 0",
        ns, cap_data[0], ndone);
    end
    total++;
    if (err_cnt !== 16'd1 || frame_cnt !== 16'd0) begin
      bad++; $display("FAIL to_cnts: err=%0d fc=%0d want 1 0",
        err_cnt, frame_cnt);
    end
    clr_mon();
    send_header();
    send_body(SPF, 1'b0);
    tick(2);
    total++;
    if (ns !== SPF || count_bad(1'b0) !== 0 || frame_cnt !== 16'd1 ||
        err_cnt !== 16'd1) begin
      bad++; $display("FAIL to_recover: n=%0d bs=%0d fc=%0d err=%0d",
        ns, count_bad(1'b0), frame_cnt, err_cnt);
    end
  endtask

  task automatic test_timeout_race();
    do_reset();
    send_header();
    send(8'h11);
    tick(TO - 1);
    send(8'h22);
    total++;
    if (frame_abort !== 1'b0) begin
      bad++; $display("FAIL race_abort: got %b want 0", frame_abort);
    end
    send(8'h33);
    total++;
    if (sample_we !== 1'b1 || sample_data !== 24'h332211 ||
        sample_index !== 11'd0) begin
      bad++; $display("FAIL race_sample: we=%b d=%h i=%0d want 1 332211 0",
        sample_we, sample_data, sample_index);
    end
    tick(3);
    total++;
    if (nabort !== 0 || err_cnt !== 16'd0) begin
      bad++; $display("FAIL race_cnts: ab=%0d err=%0d want 0 0",
        nabort, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'hAA); send(8'h00);
    send_header();
    send_body(SPF, 1'b0);
    clr_mon();
    send_header();
    send_body(1000, 1'b0);
    total++;
    if (ns !== 1000 || frame_cnt !== 16'd1 || err_cnt !== 16'd1) begin
      bad++; $display("FAIL mid_pre: n=%0d fc=%0d err=%0d want 1000 1 1",
        ns, frame_cnt, err_cnt);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({sample_data, sample_index, err_cnt, frame_cnt} !== 67'h0) begin
      bad++; $display("FAIL mid_async: d=%h i=%0d err=%0d fc=%0d want 0",
        sample_data, sample_index, err_cnt, frame_cnt);
    end
    total++;
    if ({sample_we, frame_start, frame_done, frame_abort} !== 4'b0) begin
      bad++; $display("FAIL mid_pulses: got %b%b%b%b want 0000",
        sample_we, frame_start, frame_done, frame_abort);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    clr_mon();
    send_header();
    send_body(SPF, 1'b0);
    tick(2);
    total++;
    if (ns !== SPF || count_bad(1'b0) !== 0 || frame_cnt !== 16'd1 ||
        err_cnt !== 16'd0 || nstart !== 1) begin
      bad++; $display("FAIL mid_after: n=%0d bs=%0d fc=%0d err=%0d st=%0d",
        ns, count_bad(1'b0), frame_cnt, err_cnt, nstart);
    end
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_clean_frame();
    test_sync_recovery();
    test_header_errors();
    test_data_like_sync();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Receive-side decoder for the microphone capture UART stream. It takes bytes from a UART receiver, locks onto the 0xAA 0xBB 0xCC sync header, and reassembles the following little-endian 24-bit samples into one-cycle sample strobes. It counts samples per frame and drops back to sync hunting on a bad header or an inter-byte timeout. It sits between the UART RX core and the sample consumer, such as a display buffer or loopback checker.

## Interface
Parameters:
- SAMPLES_PER_FRAME, 2048, number of 24-bit samples following each sync header; must be at least 2.
- TIMEOUT_CYCLES, 1_000_000, idle clk cycles without a byte (outside HUNT0) before the frame is aborted; must be at least 2.
- is_simulation, 0, reserved for simulation build variants; it does not change behaviour.

Ports:
- clk, input, 1, system clock; the only clock.
- reset_n, input, 1, asynchronous active-low reset.
- uart_rx_data, input, 8, received byte; valid only while uart_rx_data_we is high.
- uart_rx_data_we, input, 1, one-cycle strobe per received byte.
- sample_data, output, 24, assembled sample: byte0 goes to [7:0], byte1 to [15:8], byte2 to [23:16].
- sample_we, output, 1, one-cycle strobe; sample_data is valid on this cycle.
- sample_index, output, 11, index of the current sample within its frame (0..SAMPLES_PER_FRAME-1); valid with sample_we.
- frame_start, output, 1, one-cycle pulse after the 0xCC sync byte is accepted.
- frame_done, output, 1, one-cycle pulse coincident with the sample_we of the last sample.
- frame_abort, output, 1, one-cycle pulse on timeout inside a header or frame.
- err_cnt, output, 16, saturating count of sync mismatches plus timeouts.
- frame_cnt, output, 16, wrapping count of completed frames.

## Operation
- States: HUNT0, HUNT1, HUNT2, BYTE0, BYTE1, BYTE2. Transitions occur only on uart_rx_data_we, except for timeout.
- HUNT0:
  - 0xAA goes to HUNT1.
  - Any other byte stays in HUNT0. It is not an error.
- HUNT1:
  - 0xBB goes to HUNT2.
  - 0xAA stays in HUNT1 and increments err_cnt.
  - Any other byte goes to HUNT0 and increments err_cnt.
- HUNT2:
  - 0xCC goes to BYTE0, clears the sample counter to 0, and pulses frame_start.
  - 0xAA goes to HUNT1 and increments err_cnt.
  - Any other byte goes to HUNT0 and increments err_cnt.
- BYTE0: latches byte into [7:0], then goes to BYTE1.
- BYTE1: latches byte into [15:8], then goes to BYTE2.
- BYTE2 (third byte of a sample):
  - The full 24-bit word is registered to sample_data, sample_we is pulsed, and sample_index is set to the counter value.
  - The counter then increments.
  - If the counter held SAMPLES_PER_FRAME-1: pulse frame_done, increment frame_cnt, go to HUNT0.
  - Otherwise go to BYTE0.
- Sample bytes are never compared with sync values. 0xAA inside a frame is data.
- Timeout counter:
  - Cleared on every uart_rx_data_we, and held at 0 while in HUNT0.
  - Increments every cycle in any other state.
  - Reaching TIMEOUT_CYCLES-1 without a strobe: go to HUNT0, pulse frame_abort, increment err_cnt. No frame_done or frame_cnt change.
- err_cnt saturates at 0xFFFF. frame_cnt wraps modulo 2^16.
- sample_data holds its last value between strobes.
- Reset values: state HUNT0 and all counters 0. Every output is 0: sample_data, sample_we, sample_index, frame_start, frame_done, frame_abort, err_cnt, frame_cnt.

## Timing
- All outputs are registered.
- frame_start, sample_we and frame_done each assert exactly one clk after the uart_rx_data_we that causes them.
- Accepted byte rate is one byte per clk (back-to-back strobes). No byte is ever dropped in non-timeout operation.
- Simultaneous strobe and timeout threshold: the strobe wins. The byte is processed, the timeout counter is cleared, and there is no abort.
- reset_n asserted mid-frame: all state and outputs clear asynchronously. After release, decoding restarts in HUNT0, so a partially received frame is discarded.
- reset_n deassertion is expected synchronized externally to clk.
- Pulses never overlap except frame_done with sample_we.
- frame_abort never coincides with sample_we.

## Test plan
- **Clean frame.** Stimulus: AA BB CC, then samples i = 0..2047 with value 0x010203+i, sent LSB first, back-to-back. Response:
  - frame_start once.
  - 2048 sample_we strobes with sample_data = 0x010203+i and sample_index = i.
  - frame_done coincides with index 2047.
  - frame_cnt = 1, err_cnt = 0.
- **Sync recovery.** Stimulus: 55 AA AA BB 00 AA BB CC, then one frame. Response:
  - err_cnt = 2, from the second AA in HUNT1 and the 00 in HUNT2.
  - The frame decodes correctly.
- **Data looks like sync.** Stimulus: a frame whose samples are 0xCCBBAA. Response: all 2048 decode as 0xCCBBAA, and exactly one frame_start.
- **Timeout.** Stimulus: with TIMEOUT_CYCLES = 100, send AA BB CC plus 4 bytes, then idle for 100 cycles. Response:
  - Exactly one sample_we.
  - frame_abort 100 cycles after the last byte.
  - err_cnt = 1, frame_cnt unchanged.
  - A following clean frame decodes.
- **Timeout race.** Stimulus: a byte strobe arrives on the exact cycle the timeout threshold is reached. Response: no frame_abort, and the byte is accepted.
- **Reset mid-frame.** Stimulus: drop reset_n after 1000 samples. Response:
  - All outputs read 0 immediately.
  - After release, the next full frame yields indices 0..2047 and frame_cnt = 1.
